// File: rtl/transform_streamer.sv
// Streams one line of character pairs: line table lookup, then one mem word per beat out a valid/ready port.
// Optional TRANSFORM_STREAMER_INVERSE_EN adds a per-line 'inverse' input that swaps lhs/rhs halves.
module transform_streamer #(
    parameter int LINE_W = 6,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 6,
    parameter int CHAR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LINE_W-1:0]        line,
`ifdef TRANSFORM_STREAMER_INVERSE_EN
    input  logic                     inverse,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [LINE_W-1:0]        tbl_addr,
    input  logic [ADDR_W+LEN_W-1:0]  tbl_dout,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [2*CHAR_W-1:0]      mem_dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHAR_W-1:0]        out_lhs,
    output logic [CHAR_W-1:0]        out_rhs,
    output logic                     out_last
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        LOAD,
        READ,
        EMIT,
        FINISH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  remaining;
    logic              rd_wait;
    logic              hs;
    logic [ADDR_W-1:0] tbl_start;
    logic [LEN_W-1:0]  tbl_len;
    logic [CHAR_W-1:0] word_hi;
    logic [CHAR_W-1:0] word_lo;

    assign hs        = out_valid & out_ready;
    assign tbl_start = tbl_dout[ADDR_W+LEN_W-1:LEN_W];
    assign tbl_len   = tbl_dout[LEN_W-1:0];
    assign word_hi   = mem_dout[2*CHAR_W-1:CHAR_W];
    assign word_lo   = mem_dout[CHAR_W-1:0];

`ifdef TRANSFORM_STREAMER_INVERSE_EN
    logic inv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv <= 1'b0;
        end else if (state == IDLE && start) begin
            inv <= inverse;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = LOAD;
            LOAD:    state_nxt = (tbl_len == '0) ? FINISH : READ;
            READ:    if (!rd_wait) state_nxt = EMIT;
            EMIT:    if (hs) state_nxt = (remaining == LEN_W'(1)) ? FINISH : READ;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // mem_addr is advanced to ptr+1 on entry to EMIT, so the next word is already
    // at mem_dout when READ follows a handshake; only the first READ needs rd_wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            tbl_addr  <= '0;
            mem_addr  <= '0;
            ptr       <= '0;
            remaining <= '0;
            rd_wait   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_lhs   <= '0;
            out_rhs   <= '0;
        end else begin
            done <= (state_nxt == FINISH);
            case (state)
                IDLE: begin
                    if (start) begin
                        tbl_addr <= line;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    ptr       <= tbl_start;
                    remaining <= tbl_len;
                    mem_addr  <= tbl_start;
                    rd_wait   <= 1'b1;
                end
                READ: begin
                    if (rd_wait) begin
                        rd_wait <= 1'b0;
                    end else begin
`ifdef TRANSFORM_STREAMER_INVERSE_EN
                        out_lhs <= inv ? word_lo : word_hi;
                        out_rhs <= inv ? word_hi : word_lo;
`else
                        out_lhs <= word_hi;
                        out_rhs <= word_lo;
`endif
                        out_last  <= (remaining == LEN_W'(1));
                        out_valid <= 1'b1;
                        mem_addr  <= ptr + ADDR_W'(1);
                    end
                end
                EMIT: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        ptr       <= ptr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                FINISH: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
